// File: rtl/exec_unit.sv
// exec_unit: execute stage of the 8-bit accumulator CPU.
// Accepts one decoded instruction (opcode + effective address) per
// valid/ready handshake, performs the operand read or store against the
// external 16x8 memory, updates AC / E / Z and pulses done on retire.
// Optional feature macro: EXEC_CLA_EN (opcode 111 clears AC when defined,
// behaves as a NOP with normal EX timing when undefined).
module exec_unit #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              dec_valid,
   output logic              dec_ready,
   input  logic [2:0]        dec_opcode,
   input  logic [ADDR_W-1:0] dec_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] ac,
   output logic              e_flag,
   output logic              z_flag,
   output logic              done
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_SHL = 3'b011;
   localparam logic [2:0] OP_LDA = 3'b100;
   localparam logic [2:0] OP_STA = 3'b101;
   localparam logic [2:0] OP_CMA = 3'b110;
   localparam logic [2:0] OP_CLA = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_EX   = 2'd2,
      S_WR   = 2'd3
   } state_t;

   state_t              state_reg, state_next;
   logic [2:0]          opcode_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic [DATA_W-1:0]   ac_reg, ac_next;
   logic                e_reg, e_next;
   logic                z_reg;
   logic                ac_load;
   logic                done_reg;
   logic [DATA_W:0]     sum;

   // State register, instruction latch and retire pulse
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_reg  <= S_IDLE;
         opcode_reg <= '0;
         addr_reg   <= '0;
         done_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         done_reg  <= (state_reg == S_EX) || (state_reg == S_WR);
         if (state_reg == S_IDLE && dec_valid) begin
            opcode_reg <= dec_opcode;
            addr_reg   <= dec_addr;
         end
      end
   end

   // Next-state: IDLE dispatches by opcode class, all other states are one cycle
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         S_IDLE: begin
            if (dec_valid) begin
               unique case (dec_opcode)
                  OP_ADD, OP_SUB, OP_XOR, OP_LDA: state_next = S_RD;
                  OP_STA:                         state_next = S_WR;
                  default:                        state_next = S_EX;
               endcase
            end
         end
         S_RD:    state_next = S_EX;
         S_EX:    state_next = S_IDLE;
         S_WR:    state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Outputs decoded from state only, so both strobes drop with an async reset
   always_comb begin
      dec_ready = (state_reg == S_IDLE);
      mem_rd    = (state_reg == S_RD);
      mem_wr    = (state_reg == S_WR);
   end

   // Result computation; mem_rdata is valid in EX for memory-operand opcodes
   always_comb begin
      ac_next = ac_reg;
      e_next  = e_reg;
      ac_load = 1'b0;
      sum     = {1'b0, ac_reg} + {1'b0, mem_rdata};
      if (state_reg == S_EX) begin
         unique case (opcode_reg)
            OP_ADD: begin
               ac_next = sum[DATA_W-1:0];
               e_next  = sum[DATA_W];
               ac_load = 1'b1;
            end
            OP_SUB: begin
               ac_next = ac_reg - mem_rdata;
               e_next  = (ac_reg >= mem_rdata);
               ac_load = 1'b1;
            end
            OP_XOR: begin
               ac_next = ac_reg ^ mem_rdata;
               ac_load = 1'b1;
            end
            OP_SHL: begin
               ac_next = {ac_reg[DATA_W-2:0], 1'b0};
               e_next  = ac_reg[DATA_W-1];
               ac_load = 1'b1;
            end
            OP_LDA: begin
               ac_next = mem_rdata;
               ac_load = 1'b1;
            end
            OP_CMA: begin
               ac_next = ~ac_reg;
               ac_load = 1'b1;
            end
            OP_CLA: begin
`ifdef EXEC_CLA_EN
               ac_next = '0;
               ac_load = 1'b1;
`else
               ac_load = 1'b0;
`endif
            end
            default: ac_load = 1'b0;
         endcase
      end
   end

   // Accumulator and flags; Z follows every AC write, STA/NOP leave all untouched
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ac_reg <= '0;
         e_reg  <= 1'b0;
         z_reg  <= 1'b1;
      end else if (ac_load) begin
         ac_reg <= ac_next;
         e_reg  <= e_next;
         z_reg  <= (ac_next == '0);
      end
   end

   assign mem_addr  = addr_reg;
   assign mem_wdata = ac_reg;
   assign ac        = ac_reg;
   assign e_flag    = e_reg;
   assign z_flag    = z_reg;
   assign done      = done_reg;

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: self-checking bench for exec_unit.
// Drives directed and random instructions, models the 16x8 memory with a
// registered read port, and compares against an instruction-level model.
module tb_exec_unit;

   logic       CLK;
   logic       RST_N;
   logic       dec_valid;
   logic       dec_ready;
   logic [2:0] dec_opcode;
   logic [3:0] dec_addr;
   logic       mem_rd;
   logic       mem_wr;
   logic [3:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic [7:0] ac;
   logic       e_flag;
   logic       z_flag;
   logic       done;

   exec_unit #(.DATA_W(8), .ADDR_W(4)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .dec_valid (dec_valid),
      .dec_ready (dec_ready),
      .dec_opcode(dec_opcode),
      .dec_addr  (dec_addr),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .ac        (ac),
      .e_flag    (e_flag),
      .z_flag    (z_flag),
      .done      (done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Memory seen by the DUT: registered read, write on the WR edge, plus a
   // bench-side poke port used to preload contents.
   logic [7:0] bus_mem [16];
   logic       poke_en;
   logic [3:0] poke_addr;
   logic [7:0] poke_data;

   always @(posedge CLK) begin
      if (mem_rd) mem_rdata <= bus_mem[mem_addr];
      if (mem_wr) bus_mem[mem_addr] <= mem_wdata;
      else if (poke_en) bus_mem[poke_addr] <= poke_data;
   end

   // Reference model state: architectural AC/E/Z and memory contents
   logic [7:0] ref_mem [16];
   logic [7:0] ref_ac;
   logic       ref_e;
   logic       ref_z;

   int errors = 0;
   int checks = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      ref_ac = 8'h00;
      ref_e  = 1'b0;
      ref_z  = 1'b1;
   endtask

   // Instruction-level semantics written from the opcode table
   task automatic model_step(input logic [2:0] op, input logic [3:0] a);
      int m;
      int acc;
      m   = int'(ref_mem[a]);
      acc = int'(ref_ac);
      case (op)
         3'd0: begin acc = acc + m; ref_e = (acc > 255); acc = acc % 256; end
         3'd1: begin ref_e = (acc >= m); acc = (acc - m + 256) % 256; end
         3'd2: acc = acc ^ m;
         3'd3: begin ref_e = (acc >= 128); acc = (acc * 2) % 256; end
         3'd4: acc = m;
         3'd5: ref_mem[a] = ref_ac;
         3'd6: acc = 255 - acc;
         default: begin
`ifdef EXEC_CLA_EN
            acc = 0;
`endif
         end
      endcase
      // Z follows every AC write; STA and the opcode-111 NOP write nothing
`ifdef EXEC_CLA_EN
      if (op != 3'd5) begin
`else
      if (op != 3'd5 && op != 3'd7) begin
`endif
         ref_ac = 8'(acc);
         ref_z  = (acc == 0);
      end
   endtask

   task automatic set_mem(input logic [3:0] a, input logic [7:0] v);
      poke_en   = 1'b1;
      poke_addr = a;
      poke_data = v;
      ref_mem[a] = v;
      @(posedge CLK);
      #1;
      poke_en = 1'b0;
   endtask

   // Issue one instruction and follow it to retirement, checking strobes,
   // latency and resulting architectural state. Returns at the negedge of
   // the done cycle so the next call is accepted with no bubble.
   task automatic exec_instr(input logic [2:0] op, input logic [3:0] a);
      bit         memop;
      int         lat;
      int         n;
      bit         got;
      logic [7:0] st_data;
      memop   = (op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd4);
      lat     = memop ? 3 : 2;
      st_data = ref_ac;
      check_val("ready_at_issue", dec_ready, 1);
      dec_valid  = 1'b1;
      dec_opcode = op;
      dec_addr   = a;
      @(posedge CLK);
      #1;
      dec_valid  = 1'b0;
      dec_opcode = 3'($urandom);
      dec_addr   = 4'($urandom);
      model_step(op, a);
      n   = 0;
      got = 1'b0;
      while (!got && n < 8) begin
         @(negedge CLK);
         n++;
         check_val("mem_rd", mem_rd, (memop && n == 1));
         check_val("mem_wr", mem_wr, (op == 3'd5 && n == 1));
         if (n == 1 && (memop || op == 3'd5))
            check_val("mem_addr", mem_addr, a);
         if (n == 1 && op == 3'd5)
            check_val("mem_wdata", mem_wdata, st_data);
         if (done) got = 1'b1;
      end
      check_val("latency", n, lat);
      check_val("ready_at_done", dec_ready, 1);
      check_val("ac", ac, ref_ac);
      check_val("e_flag", e_flag, ref_e);
      check_val("z_flag", z_flag, ref_z);
      if (op == 3'd5)
         check_val("mem_store", bus_mem[a], ref_mem[a]);
      $display("instr op=%0d addr=%0d ac=%02h e=%0b z=%0b lat=%0d", op, a, ac, e_flag, z_flag, n);
   endtask

   initial begin
      RST_N      = 1'b0;
      dec_valid  = 1'b0;
      dec_opcode = 3'd0;
      dec_addr   = 4'd0;
      poke_en    = 1'b0;
      poke_addr  = 4'd0;
      poke_data  = 8'd0;
      model_reset();
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);

      // Reset values
      check_val("rst_ac", ac, 8'h00);
      check_val("rst_z", z_flag, 1);
      check_val("rst_e", e_flag, 0);
      check_val("rst_ready", dec_ready, 1);
      check_val("rst_mem_rd", mem_rd, 0);
      check_val("rst_mem_wr", mem_wr, 0);
      check_val("rst_done", done, 0);

      for (int i = 0; i < 16; i++) set_mem(4'(i), 8'($urandom));

      // LDA then ADD with carry out
      set_mem(4'd3, 8'hF0);
      set_mem(4'd4, 8'h20);
      exec_instr(3'd4, 4'd3);
      exec_instr(3'd0, 4'd4);
      check_val("plan_add_ac", ac, 8'h10);
      check_val("plan_add_e", e_flag, 1);

      // SUB with borrow, then SUB to zero without borrow
      set_mem(4'd6, 8'h05);
      set_mem(4'd7, 8'h07);
      set_mem(4'd8, 8'hFE);
      exec_instr(3'd4, 4'd6);
      exec_instr(3'd1, 4'd7);
      check_val("plan_sub1_ac", ac, 8'hFE);
      exec_instr(3'd1, 4'd8);
      check_val("plan_sub2_z", z_flag, 1);

      // SHL with carry out, then STA back-to-back
      set_mem(4'd10, 8'h81);
      exec_instr(3'd4, 4'd10);
      exec_instr(3'd3, 4'd0);
      check_val("plan_shl_ac", ac, 8'h02);
      exec_instr(3'd5, 4'd9);
      check_val("plan_sta_mem", bus_mem[9], 8'h02);

      // CMA issued in the done cycle of LDA
      set_mem(4'd11, 8'h0F);
      exec_instr(3'd4, 4'd11);
      exec_instr(3'd6, 4'd0);
      check_val("plan_cma_ac", ac, 8'hF0);

      // done is a single-cycle pulse
      @(negedge CLK);
      check_val("done_pulse", done, 0);

      // Reset during RD of LDA 5
      dec_valid  = 1'b1;
      dec_opcode = 3'd4;
      dec_addr   = 4'd5;
      @(posedge CLK);
      #1;
      dec_valid = 1'b0;
      @(negedge CLK);
      check_val("rd_before_rst", mem_rd, 1);
      #2;
      RST_N = 1'b0;
      #1;
      check_val("rst_async_rd", mem_rd, 0);
      check_val("rst_async_ac", ac, 8'h00);
      check_val("rst_async_ready", dec_ready, 1);
      model_reset();
      @(negedge CLK);
      RST_N = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         check_val("no_done_after_rst", done, 0);
      end
      check_val("rst_z_after", z_flag, 1);

      // Opcode 111 with a nonzero accumulator
      set_mem(4'd12, 8'h3C);
      exec_instr(3'd4, 4'd12);
      exec_instr(3'd7, 4'd0);
`ifdef EXEC_CLA_EN
      check_val("plan_cla_ac", ac, 8'h00);
`else
      check_val("plan_nop_ac", ac, 8'h3C);
`endif

      // Random instruction stream with occasional gaps and memory updates
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 5) == 0)
            set_mem(4'($urandom), 8'($urandom));
         if ($urandom_range(0, 4) == 0) begin
            @(negedge CLK);
            check_val("idle_done", done, 0);
         end
         exec_instr(3'($urandom_range(0, 7)), 4'($urandom));
      end

      @(negedge CLK);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time limit so the bench can never hang
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/exec_unit.md
# exec_unit

Execute stage of the 8-bit accumulator CPU, directly downstream of the fetch/decode sequencer. It accepts one decoded instruction at a time (3-bit opcode plus a 4-bit effective address with indirection already resolved) over a valid/ready handshake. It performs the operand read or store against the 16x8 memory, computes with the accumulator, updates the E (carry) and Z flags, and pulses `done` when the instruction retires.

## Interface
- `DATA_W`, 8, accumulator and memory word width
- `ADDR_W`, 4, memory address width
- `CLK`  in  1  single clock; all state updates on rising edge
- `RST_N`  in  1  asynchronous, active-low reset
- `dec_valid`  in  1  decoded instruction present
- `dec_ready`  out  1  execute stage can accept an instruction
- `dec_opcode`  in  3  operation code
- `dec_addr`  in  ADDR_W  effective operand address
- `mem_rd`  out  1  memory read strobe
- `mem_wr`  out  1  memory write strobe
- `mem_addr`  out  ADDR_W  memory address, always the latched address
- `mem_wdata`  out  DATA_W  store data, always `ac`
- `mem_rdata`  in  DATA_W  read data, valid one cycle after `mem_rd`
- `ac`  out  DATA_W  accumulator
- `e_flag`  out  1  carry/no-borrow flag
- `z_flag`  out  1  high when `ac` == 0 after the last AC write
- `done`  out  1  one-cycle retire pulse

## Operation
- Opcodes:
  - 000 ADD: {E,AC} = AC + M, 9-bit sum.
  - 001 SUB: AC = AC − M mod 256; E = 1 iff AC ≥ M (unsigned, no borrow).
  - 010 XOR: AC ^= M; E unchanged.
  - 011 SHL: {E,AC} = {AC,1'b0}.
  - 100 LDA: AC = M; E unchanged.
  - 101 STA: M[addr] = AC.
  - 110 CMA: AC = ~AC; E unchanged.
  - 111 CLA: AC = 0; E unchanged (see Configuration).
- Z is recomputed on every AC write. STA leaves AC, E and Z unchanged.
- States: IDLE, RD, EX, WR.
  - IDLE: `dec_ready`=1. On `dec_valid`, latch opcode and address, then go to:
    - RD for opcodes 000/001/010/100;
    - WR for 101;
    - EX for 011/110/111.
  - RD: `mem_rd`=1 → EX.
  - EX: register the result into AC/E/Z; set `done` next cycle → IDLE.
  - WR: `mem_wr`=1 for exactly one cycle; set `done` next cycle → IDLE.
- `mem_rd` and `mem_wr` are decoded from state only and are never high together.
- `dec_opcode` and `dec_addr` are sampled only on the accept edge; changes while `dec_ready`=0 are ignored.
- `dec_valid` while not in IDLE is not accepted; upstream holds it.

## Timing
- Reset values: state IDLE, `ac`=0, `e_flag`=0, `z_flag`=1, `done`=0, `mem_rd`=0, `mem_wr`=0, `dec_ready`=1, latched opcode/address 0.
- Accept edge = cycle 0.
  - Register ops (011/110/111): EX in cycle 1, `done` and new `ac` visible in cycle 2.
  - STA: WR in cycle 1 (memory writes on that edge), `done` in cycle 2.
  - Memory ops: RD in cycle 1, EX in cycle 2 consumes `mem_rdata`, `done` and new `ac` in cycle 3.
- `done` is registered and high for exactly one cycle. `dec_ready` is high in the same cycle, so a new instruction may be accepted while `done`=1 (back-to-back, no bubble).
- Reset asserted mid-instruction (any state) immediately returns to IDLE, drops the strobes asynchronously, and discards the instruction. No `done` is produced for it.

## Configuration
- `EXEC_CLA_EN` defined: opcode 111 clears AC and sets Z=1.
- `EXEC_CLA_EN` undefined: opcode 111 is a NOP. It follows the same EX path and timing and pulses `done`, but AC, E and Z are unchanged.

## Test plan
- Reset release → `ac`=0x00, `z_flag`=1, `e_flag`=0, `dec_ready`=1, no strobes.
- M[3]=0xF0; LDA 3, then ADD with M[4]=0x20 → `ac`=0x10, `e_flag`=1, `z_flag`=0; `done` 3 cycles after each accept.
- AC=0x05; SUB with M=0x07 → `ac`=0xFE, `e_flag`=0. Then SUB with M=0xFE → `ac`=0x00, `e_flag`=1, `z_flag`=1.
- AC=0x81; SHL → `ac`=0x02, `e_flag`=1. Then STA 9 → `mem_wr` for one cycle at addr 9 with data 0x02, flags unchanged, `done` 2 cycles after accept.
- CMA issued on the `done` cycle of the previous instruction → accepted without a bubble. AC=0x0F → 0xF0.
- Reset pulsed during RD of LDA 5 → `mem_rd` drops immediately, `ac`=0, no `done`. Opcode 111 with AC=0x3C → 0x00 with the macro, 0x3C without.
